jtag_byte_deserializer: RTL and testbench

// - Converts the serial TDI bitstream in the user DR scan chain into a byte stream for the puzzle solver.
// - Sits between the TAP controller state outputs and the solver core inside user_logic.
// - Clocked by tck. TDI is sampled LSB-first.
// - Provides a one-entry output register with valid/ready handshake and sticky error flags.
// - JTAG cannot be stalled, so backpressure is detected and flagged, never applied.

---
 rtl/jtag_pkg.sv | 16 +
 rtl/jtag_byte_deserializer.sv | 123 ++++++++++++
 tb/tb_jtag_byte_deserializer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// Shared JTAG user-chain types and defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jtag_pkg;

  // TAP state qualifiers for the user DR chain.
  typedef struct packed {
    logic capture;
    logic shift;
    logic update;
    logic user;
  } tap_ctrl_t;

  localparam int DEFAULT_DATA_WIDTH = 8;

endpackage : jtag_pkg

// File: rtl/jtag_byte_deserializer.sv
// Deserialises LSB-first TDI from the user DR chain into DATA_WIDTH-bit words.
// Latency: word visible on out_data/out_valid one tck after its last bit is shifted in.
// Backpressure: never applied (JTAG cannot stall); a word completing over an undelivered
//   one overwrites it and sets the sticky overflow flag.
//
// Ports:
//   tck, test_logic_reset        : clock and synchronous active-high reset
//   ir_is_user, capture_dr,
//   shift_dr, update_dr          : TAP state qualifiers
//   tdi / tdo                    : serial in / loopback of shift register bit 0
//   out_data, out_valid,
//   out_ready                    : one-entry registered output with valid/ready
//   word_count                   : words accepted by the consumer (wraps)
//   overflow, partial_frame      : sticky error flags, cleared only by reset
module jtag_byte_deserializer
  import jtag_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  tck,
  input  logic                  test_logic_reset,
  input  logic                  ir_is_user,
  input  logic                  capture_dr,
  input  logic                  shift_dr,
  input  logic                  update_dr,
  input  logic                  tdi,
  output logic                  tdo,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  overflow,
  output logic                  partial_frame
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  tap_ctrl_t tap;
  assign tap = '{capture: capture_dr, shift: shift_dr, update: update_dr, user: ir_is_user};

  logic [DATA_WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;
  logic                  overflow_q, overflow_d;
  logic                  partial_frame_q, partial_frame_d;

  logic shift_en;
  logic word_done;
  logic xfer;

  assign shift_en  = tap.user & tap.shift;
  assign word_done = shift_en && (bit_cnt_q == LAST_BIT);
  // Handshake is a consumer-side event and does not depend on the TAP state.
  assign xfer      = out_valid_q & out_ready;

  always_comb begin
    shift_reg_d     = shift_reg_q;
    bit_cnt_d       = bit_cnt_q;
    out_data_d      = out_data_q;
    out_valid_d     = out_valid_q;
    word_count_d    = word_count_q;
    overflow_d      = overflow_q;
    partial_frame_d = partial_frame_q;

    if (shift_en) begin
      shift_reg_d = {tdi, shift_reg_q[DATA_WIDTH-1:1]};
      bit_cnt_d   = word_done ? '0 : bit_cnt_q + 1'b1;
    end else if (tap.user && tap.capture) begin
      // shift_reg is kept so the tdo loopback stays coherent across frames.
      bit_cnt_d = '0;
    end else if (tap.user && tap.update && (bit_cnt_q != '0)) begin
      partial_frame_d = 1'b1;
      bit_cnt_d       = '0;
    end

    if (xfer) begin
      word_count_d = word_count_q + 1'b1;
    end

    if (word_done) begin
      // A simultaneous transfer frees the slot, so only an unaccepted word overflows.
      if (out_valid_q && !out_ready) begin
        overflow_d = 1'b1;
      end
      out_data_d  = {tdi, shift_reg_q[DATA_WIDTH-1:1]};
      out_valid_d = 1'b1;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge tck) begin
    if (test_logic_reset) begin
      shift_reg_q     <= '0;
      bit_cnt_q       <= '0;
      out_data_q      <= '0;
      out_valid_q     <= 1'b0;
      word_count_q    <= '0;
      overflow_q      <= 1'b0;
      partial_frame_q <= 1'b0;
    end else begin
      shift_reg_q     <= shift_reg_d;
      bit_cnt_q       <= bit_cnt_d;
      out_data_q      <= out_data_d;
      out_valid_q     <= out_valid_d;
      word_count_q    <= word_count_d;
      overflow_q      <= overflow_d;
      partial_frame_q <= partial_frame_d;
    end
  end

  assign tdo           = shift_reg_q[0];
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign word_count    = word_count_q;
  assign overflow      = overflow_q;
  assign partial_frame = partial_frame_q;

endmodule : jtag_byte_deserializer

// File: tb/tb_jtag_byte_deserializer.sv
// Self-checking bench for jtag_byte_deserializer: vector table, directed sequences,
// and randomized traffic compared against a bit-queue reference model.
// Inputs change 1ns after the rising tck edge; outputs are sampled 1ns after it.
module tb_jtag_byte_deserializer;
  import jtag_pkg::*;

  localparam int W  = 8;
  localparam int CW = 16;

  logic          tck = 1'b0;
  logic          test_logic_reset, ir_is_user, capture_dr, shift_dr, update_dr, tdi, out_ready;
  logic          tdo, out_valid, overflow, partial_frame;
  logic [W-1:0]  out_data;
  logic [CW-1:0] word_count;

  jtag_byte_deserializer #(.DATA_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .tck              (tck),
    .test_logic_reset (test_logic_reset),
    .ir_is_user       (ir_is_user),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .update_dr        (update_dr),
    .tdi              (tdi),
    .tdo              (tdo),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .word_count       (word_count),
    .overflow         (overflow),
    .partial_frame    (partial_frame)
  );

  always #5 tck = ~tck;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit        hist[$];   // most recent W shifted bits (tdo view)
  bit        bits[$];   // bits of the word currently being assembled
  bit [W-1:0]  m_data;
  bit          m_valid, m_ovf, m_part;
  bit [CW-1:0] m_cnt;

  task automatic model_edge();
    bit done;
    bit [W-1:0] word;
    bit tr;
    done = 0;
    word = '0;
    if (test_logic_reset) begin
      hist.delete(); bits.delete();
      m_data = '0; m_valid = 0; m_ovf = 0; m_part = 0; m_cnt = '0;
      return;
    end
    tr = m_valid && out_ready;
    if (ir_is_user && shift_dr) begin
      hist.push_back(tdi);
      if (hist.size() > W) void'(hist.pop_front());
      bits.push_back(tdi);
      if (bits.size() == W) begin
        for (int i = 0; i < W; i++) word[i] = bits[i];
        bits.delete();
        done = 1;
      end
    end else if (ir_is_user && capture_dr) begin
      bits.delete();
    end else if (ir_is_user && update_dr) begin
      if (bits.size() != 0) m_part = 1;
      bits.delete();
    end
    if (tr) m_cnt = m_cnt + 1'b1;
    if (done) begin
      if (m_valid && !tr) m_ovf = 1;
      m_data  = word;
      m_valid = 1;
    end else if (tr) begin
      m_valid = 0;
    end
  endtask

  function automatic bit m_tdo();
    return (hist.size() == W) ? hist[0] : 1'b0;
  endfunction

  task automatic cmp_model(input string tag);
    chk({tag, ".tdo"},        tdo,           m_tdo());
    chk({tag, ".out_valid"},  out_valid,     m_valid);
    chk({tag, ".out_data"},   out_data,      m_data);
    chk({tag, ".word_count"}, word_count,    m_cnt);
    chk({tag, ".overflow"},   overflow,      m_ovf);
    chk({tag, ".partial"},    partial_frame, m_part);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic rst, input logic user, input logic cap, input logic sh,
                       input logic upd, input logic d, input logic rdy);
    test_logic_reset = rst; ir_is_user = user; capture_dr = cap;
    shift_dr = sh; update_dr = upd; tdi = d; out_ready = rdy;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge tck);
    #1;
    cmp_model(tag);
  endtask

  task automatic shift_word(input logic [W-1:0] w, input logic rdy, input string tag);
    for (int i = 0; i < W; i++) begin
      drive(0, 1, 0, 1, 0, w[i], rdy);
      step(tag);
    end
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    step("reset");
    drive(0, 1, 0, 0, 0, 0, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic rst, user, cap, sh, upd, d, rdy;
    logic          e_valid;
    logic [W-1:0]  e_data;
    logic [CW-1:0] e_cnt;
    logic          e_ovf, e_part;
  } vec_t;

  vec_t vecs[11];

  logic [W-1:0] rx[$];
  logic [W-1:0] exp_words[4];
  logic         tdo_first;

  initial begin
    // Reset, then 0x5E LSB-first (0,1,1,1,1,0,1,0) with out_ready=1, then one idle edge.
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0,  0, 8'h00, 16'd0, 0, 0};
    vecs[1]  = '{0, 1, 0, 1, 0, 0, 1,  0, 8'h00, 16'd0, 0, 0};
    vecs[2]  = '{0, 1, 0, 1, 0, 1, 1,  0, 8'h00, 16'd0, 0, 0};
    vecs[3]  = '{0, 1, 0, 1, 0, 1, 1,  0, 8'h00, 16'd0, 0, 0};
    vecs[4]  = '{0, 1, 0, 1, 0, 1, 1,  0, 8'h00, 16'd0, 0, 0};
    vecs[5]  = '{0, 1, 0, 1, 0, 1, 1,  0, 8'h00, 16'd0, 0, 0};
    vecs[6]  = '{0, 1, 0, 1, 0, 0, 1,  0, 8'h00, 16'd0, 0, 0};
    vecs[7]  = '{0, 1, 0, 1, 0, 1, 1,  0, 8'h00, 16'd0, 0, 0};
    vecs[8]  = '{0, 1, 0, 1, 0, 0, 1,  1, 8'h5E, 16'd0, 0, 0};
    vecs[9]  = '{0, 1, 0, 0, 0, 0, 1,  0, 8'h5E, 16'd1, 0, 0};
    vecs[10] = '{0, 1, 0, 0, 0, 0, 1,  0, 8'h5E, 16'd1, 0, 0};

    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge tck);
    #1;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].rst, vecs[i].user, vecs[i].cap, vecs[i].sh, vecs[i].upd, vecs[i].d, vecs[i].rdy);
      model_edge();
      @(posedge tck);
      #1;
      chk($sformatf("vec%0d.out_valid", i),  out_valid,     vecs[i].e_valid);
      chk($sformatf("vec%0d.out_data", i),   out_data,      vecs[i].e_data);
      chk($sformatf("vec%0d.word_count", i), word_count,    vecs[i].e_cnt);
      chk($sformatf("vec%0d.overflow", i),   overflow,      vecs[i].e_ovf);
      chk($sformatf("vec%0d.partial", i),    partial_frame, vecs[i].e_part);
    end

    // Back-to-back "^v<>" with out_ready=1: all four delivered in order.
    exp_words[0] = 8'h5E; exp_words[1] = 8'h76; exp_words[2] = 8'h3C; exp_words[3] = 8'h3E;
    do_reset();
    rx.delete();
    for (int w = 0; w < 4; w++) begin
      for (int b = 0; b < W; b++) begin
        drive(0, 1, 0, 1, 0, exp_words[w][b], 1);
        step("b2b");
        if (out_valid) rx.push_back(out_data);
      end
    end
    drive(0, 1, 0, 0, 0, 0, 1);
    step("b2b_idle");
    chk("b2b.rx_count", rx.size(), 4);
    for (int w = 0; w < 4; w++)
      chk($sformatf("b2b.word%0d", w), (w < rx.size()) ? rx[w] : 8'hxx, exp_words[w]);
    chk("b2b.word_count", word_count, 16'd4);
    chk("b2b.overflow", overflow, 1'b0);

    // Stalled consumer: second word overwrites the first and flags overflow.
    do_reset();
    shift_word(8'h3C, 0, "stall");
    shift_word(8'h3E, 0, "stall");
    chk("stall.out_data", out_data, 8'h3E);
    chk("stall.overflow", overflow, 1'b1);
    chk("stall.word_count", word_count, 16'd0);
    drive(0, 1, 0, 0, 0, 0, 1);
    step("stall_release");
    chk("stall.word_count_after", word_count, 16'd1);
    chk("stall.out_valid_after", out_valid, 1'b0);
    chk("stall.overflow_sticky", overflow, 1'b1);

    // Five bits then Update-DR: partial frame, no word; next byte intact.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 1, 0, 1'b1, 1);
      step("partial");
    end
    drive(0, 1, 0, 0, 1, 0, 1);
    step("partial_upd");
    chk("partial.flag", partial_frame, 1'b1);
    chk("partial.no_valid", out_valid, 1'b0);
    shift_word(8'h76, 1, "partial_next");
    chk("partial.next_valid", out_valid, 1'b1);
    chk("partial.next_data", out_data, 8'h76);
    // Update-DR with an empty word is harmless.
    drive(0, 1, 0, 0, 1, 0, 1);
    step("partial_upd_empty");

    // Reset after three bits of a word, with a word pending.
    do_reset();
    shift_word(8'hFF, 0, "midrst_fill");
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 0, 1'b1, 0);
      step("midrst");
    end
    drive(1, 1, 0, 1, 0, 1'b1, 0);
    step("midrst_rst");
    chk("midrst.tdo", tdo, 1'b0);
    chk("midrst.out_valid", out_valid, 1'b0);
    chk("midrst.out_data", out_data, 8'h00);
    chk("midrst.word_count", word_count, 16'd0);
    chk("midrst.overflow", overflow, 1'b0);
    chk("midrst.partial", partial_frame, 1'b0);
    shift_word(8'h3C, 0, "midrst_clean");
    chk("midrst.clean_data", out_data, 8'h3C);
    chk("midrst.clean_valid", out_valid, 1'b1);

    // Capture-DR mid-word restarts the bit count but keeps the shift register.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 1, 0, 1'b0, 1);
      step("cap");
    end
    drive(0, 1, 1, 0, 0, 0, 1);
    step("cap_capture");
    shift_word(8'hA1, 1, "cap_next");
    chk("cap.data", out_data, 8'hA1);
    chk("cap.partial", partial_frame, 1'b0);

    // Non-user instruction: shifting has no effect; tdo stays at shift_reg[0]=1.
    do_reset();
    shift_word(8'hA5, 0, "nonuser_fill");
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, (i % 5) == 2, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 0);
      step("nonuser");
      chk("nonuser.tdo", tdo, 1'b1);
      chk("nonuser.data", out_data, 8'hA5);
    end
    tdo_first = tdo;
    chk("nonuser.valid", out_valid, 1'b1);

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int sel;
      sel = $urandom_range(0, 99);
      drive(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 9) != 0),
            (sel >= 80 && sel < 88),
            (sel < 72),
            (sel >= 88 && sel < 94),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) != 0));
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_jtag_byte_deserializer
